// File: rtl/bitrev_stream_reorder.sv
// Ping-pong frame buffer: accepts samples in natural order, one per clock, and emits
// each frame in bit-reversed or natural order. The order is chosen per frame by bitrev_en.
module bitrev_stream_reorder #(
  parameter int FFT_POINTS = 16,
  parameter int DATA_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  bitrev_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);
  localparam int LOG2 = (FFT_POINTS > 1) ? $clog2(FFT_POINTS) : 1;
  localparam logic [LOG2-1:0] LAST_IDX = LOG2'(FFT_POINTS - 1);

  generate
    if (FFT_POINTS < 2 || (FFT_POINTS & (FFT_POINTS - 1)) != 0) begin : g_bad_points
      $error("bitrev_stream_reorder: FFT_POINTS must be a power of 2 and >= 2");
    end
  endgenerate

  logic                  r_wr_bank, r_rd_bank;
  logic [LOG2-1:0]       r_wr_idx, r_rd_idx;
  logic [1:0]            r_full, r_mode;
  logic                  r_out_valid, r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0] r_mem [2*FFT_POINTS];

  logic            w_wr_fire, w_wr_last, w_load, w_rd_last;
  logic [LOG2-1:0] w_rd_rev, w_rd_addr;
  logic [1:0]      w_full_nxt;

  assign in_ready  = !r_full[r_wr_bank];
  assign w_wr_fire = in_valid && in_ready;
  assign w_wr_last = (r_wr_idx == LAST_IDX);

  // The output register reloads whenever it is empty or being consumed this cycle.
  assign w_load    = r_full[r_rd_bank] && (!r_out_valid || out_ready);
  assign w_rd_last = (r_rd_idx == LAST_IDX);

  for (genvar j = 0; j < LOG2; j++) begin : g_rev
    assign w_rd_rev[j] = r_rd_idx[LOG2-1-j];
  end

  assign w_rd_addr = r_mode[r_rd_bank] ? w_rd_rev : r_rd_idx;

  // The writer and the reader only ever touch opposite banks' full bits in the same cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_fire && w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_load && w_rd_last)    w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[{r_wr_bank, r_wr_idx}] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_idx    <= '0;
      r_full      <= '0;
      r_mode      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire) begin
        r_wr_idx <= r_wr_idx + LOG2'(1);
        if (r_wr_idx == '0) r_mode[r_wr_bank] <= bitrev_en;
        if (w_wr_last)      r_wr_bank <= ~r_wr_bank;
      end
      if (w_load) begin
        r_out_data  <= r_mem[{r_rd_bank, w_rd_addr}];
        r_out_valid <= 1'b1;
        r_out_last  <= w_rd_last;
        r_rd_idx    <= r_rd_idx + LOG2'(1);
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule
